// File: rtl/spi_wb_regs.sv
// spi_wb_regs: Wishbone slave register bank and control block for the SPI master.
//
// Ports:
//   wb_clk_in, wb_rst           system clock, asynchronous active-high reset
//   wb_adr_i/dat_i/sel_i/we_i,
//   wb_stb_i/cyc_i              Wishbone request (address bits [4:2] decoded)
//   wb_dat_o/ack_o/err_o        registered response; err for address slot 7
//   wb_int_o                    transfer-complete interrupt
//   p_out, tip                  received character and transfer-in-progress
//   go, len, lsb, rx_negedge,
//   tx_negedge                  transfer configuration to the shift register
//   latch, byte_sel, p_in       parallel-load strobes and data (combinational)
//   divider                     SPI clock divider value
//   ss_pad_o                    slave selects, active-low
module spi_wb_regs #(
  parameter int unsigned SS_NB = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_int_o,
  input  logic [7:0]       p_out,
  input  logic             tip,
  output logic             go,
  output logic [2:0]       len,
  output logic             lsb,
  output logic             rx_negedge,
  output logic             tx_negedge,
  output logic [3:0]       latch,
  output logic [3:0]       byte_sel,
  output logic [31:0]      p_in,
  output logic [DIV_W-1:0] divider,
  output logic [SS_NB-1:0] ss_pad_o
);

  logic [2:0]       adr;
  logic             acc, wr;
  logic [31:0]      rd_data;

  logic             ack_q, ack_d, err_q, err_d, int_q, int_d, tip_q;
  logic [31:0]      dat_q, dat_d;
  logic [2:0]       len_q, len_d;
  logic             go_q, go_d, rxneg_q, rxneg_d, txneg_q, txneg_d;
  logic             lsb_q, lsb_d, ie_q, ie_d, ass_q, ass_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SS_NB-1:0] ss_q, ss_d;

  logic             unused_ok;
  assign unused_ok = ^wb_adr_i[1:0];

  assign adr = wb_adr_i[4:2];
  // The pending response masks the request so each access is acked exactly once.
  assign acc = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign wr  = acc & wb_we_i;

  always_comb begin
    rd_data = '0;
    case (adr)
      3'd0:    rd_data[7:0] = p_out;
      3'd4:    rd_data = {18'b0, ass_q, ie_q, lsb_q, txneg_q, rxneg_q,
                          go_q | tip, 5'b0, len_q};
      3'd5:    rd_data[DIV_W-1:0] = div_q;
      3'd6:    rd_data[SS_NB-1:0] = ss_q;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    latch = '0;
    if (wr && !adr[2]) latch[adr[1:0]] = 1'b1;
  end
  assign byte_sel = wb_sel_i;
  assign p_in     = wb_dat_i;

  always_comb begin
    ack_d   = acc & (adr != 3'd7);
    err_d   = acc & (adr == 3'd7);
    dat_d   = acc ? rd_data : dat_q;
    len_d   = len_q;
    go_d    = go_q;
    rxneg_d = rxneg_q;
    txneg_d = txneg_q;
    lsb_d   = lsb_q;
    ie_d    = ie_q;
    ass_d   = ass_q;
    div_d   = div_q;
    ss_d    = ss_q;
    int_d   = int_q;

    if (tip) go_d = 1'b0;

    // CTRL and DIVIDER are frozen while a transfer runs; the write is still acked.
    if (wr && adr == 3'd4 && !tip) begin
      if (wb_sel_i[0]) len_d = wb_dat_i[2:0];
      if (wb_sel_i[1]) begin
        go_d    = wb_dat_i[8];
        rxneg_d = wb_dat_i[9];
        txneg_d = wb_dat_i[10];
        lsb_d   = wb_dat_i[11];
        ie_d    = wb_dat_i[12];
        ass_d   = wb_dat_i[13];
      end
    end

    if (wr && adr == 3'd5 && !tip) begin
      for (int unsigned i = 0; i < DIV_W; i++) begin
        if (i < 16 && wb_sel_i[i / 8]) div_d[i] = wb_dat_i[i];
      end
    end

    if (wr && adr == 3'd6 && wb_sel_i[0]) ss_d = wb_dat_i[SS_NB-1:0];

    // A completion edge outranks a clearing ack in the same cycle.
    if (tip_q && !tip && ie_q) int_d = 1'b1;
    else if (ack_q)            int_d = 1'b0;
  end

  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      int_q   <= 1'b0;
      tip_q   <= 1'b0;
      dat_q   <= '0;
      len_q   <= '0;
      go_q    <= 1'b0;
      rxneg_q <= 1'b0;
      txneg_q <= 1'b0;
      lsb_q   <= 1'b0;
      ie_q    <= 1'b0;
      ass_q   <= 1'b0;
      div_q   <= '1;
      ss_q    <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      int_q   <= int_d;
      tip_q   <= tip;
      dat_q   <= dat_d;
      len_q   <= len_d;
      go_q    <= go_d;
      rxneg_q <= rxneg_d;
      txneg_q <= txneg_d;
      lsb_q   <= lsb_d;
      ie_q    <= ie_d;
      ass_q   <= ass_d;
      div_q   <= div_d;
      ss_q    <= ss_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_int_o   = int_q;
  assign wb_dat_o   = dat_q;
  assign go         = go_q;
  assign len        = len_q;
  assign lsb        = lsb_q;
  assign rx_negedge = rxneg_q;
  assign tx_negedge = txneg_q;
  assign divider    = div_q;
  assign ss_pad_o   = ~(ss_q & {SS_NB{ass_q ? tip : 1'b1}});

endmodule

// File: tb/tb_spi_wb_regs.sv
// tb_spi_wb_regs: directed bench for spi_wb_regs. Bus tasks push the expected
// response into a queue; a monitor pops it whenever ack or err appears.
module tb_spi_wb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [31:0] dat_i, dat_o, p_in;
  logic [3:0]  sel, latch, byte_sel;
  logic        we, stb, cyc, ack, err, irq;
  logic [7:0]  p_out;
  logic        tip, go, lsb, rxn, txn;
  logic [2:0]  len;
  logic [15:0] divider;
  logic [7:0]  ss_pad;

  int compared = 0;
  int failed   = 0;

  typedef struct {
    string       name;
    logic        is_err;
    logic        chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  spi_wb_regs #(.SS_NB(8), .DIV_W(16)) dut (
    .wb_clk_in(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack), .wb_err_o(err), .wb_int_o(irq),
    .p_out(p_out), .tip(tip), .go(go), .len(len), .lsb(lsb),
    .rx_negedge(rxn), .tx_negedge(txn), .latch(latch), .byte_sel(byte_sel),
    .p_in(p_in), .divider(divider), .ss_pad_o(ss_pad)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack/err must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (ack || err)) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("unexpected_response", {30'b0, ack, err}, 32'h0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_kind"}, {30'b0, ack, err}, {30'b0, !e.is_err, e.is_err});
        if (e.chk) check({e.name, "_data"}, dat_o, e.data);
      end
    end
  end

  task automatic bus_start(input logic [4:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic is_err, input logic chk,
                           input logic [31:0] exp, input string nm);
    exp_t e;
    @(posedge clk); #1;
    adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    e.name = nm; e.is_err = is_err; e.chk = chk; e.data = exp;
    sb.push_back(e);
  endtask

  task automatic bus_wait(input string nm);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ack || err) && n < 8);
    if (!(ack || err)) check({nm, "_timeout"}, 32'd0, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    bus_start(a, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, exp, nm);
    bus_wait(nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    input string nm);
    bus_start(a, 1'b1, d, s, 1'b0, 1'b0, 32'h0, nm);
    bus_wait(nm);
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 0; stb = 0; cyc = 0;
    p_out = 8'h00; tip = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_pad", {24'b0, ss_pad}, 32'hFF);
    check("rst_int", {31'b0, irq}, 32'h0);
    check("rst_go", {31'b0, go}, 32'h0);
    check("rst_ack_err", {30'b0, ack, err}, 32'h0);
    check("rst_divider", {16'b0, divider}, 32'h0000FFFF);
    check("rst_dat_o", dat_o, 32'h0);
    rst = 1'b0;

    rd(5'h10, 32'h0, "rd_ctrl_rst");
    rd(5'h14, 32'h0000FFFF, "rd_div_rst");
    rd(5'h18, 32'h0, "rd_ss_rst");

    // TX0 load strobe is present only during the request cycle
    bus_start(5'h00, 1'b1, 32'h000000A5, 4'b0001, 1'b0, 1'b0, 32'h0, "wr_tx0");
    #1;
    check("tx0_latch", {28'b0, latch}, 32'h1);
    check("tx0_p_in", p_in, 32'hA5);
    check("tx0_byte_sel", {28'b0, byte_sel}, 32'h1);
    bus_wait("wr_tx0");
    check("tx0_latch_after", {28'b0, latch}, 32'h0);

    // TX3 strobe
    bus_start(5'h0C, 1'b1, 32'h11223344, 4'b1000, 1'b0, 1'b0, 32'h0, "wr_tx3");
    #1;
    check("tx3_latch", {28'b0, latch}, 32'h8);
    bus_wait("wr_tx3");

    // Transfer with GO + IE
    wr(5'h10, 32'h00001100, 4'b0011, "wr_ctrl_go");
    check("go_set", {31'b0, go}, 32'h1);
    tip = 1'b1; p_out = 8'h3C;
    @(posedge clk); #1;
    check("go_clr_on_tip", {31'b0, go}, 32'h0);
    rd(5'h10, 32'h00001100, "rd_ctrl_busy");
    wr(5'h14, 32'h00000003, 4'b0011, "wr_div_busy");
    wr(5'h10, 32'h00000007, 4'b0011, "wr_ctrl_busy");
    rd(5'h14, 32'h0000FFFF, "rd_div_unchanged");
    rd(5'h10, 32'h00001100, "rd_ctrl_unchanged");
    check("int_before_fall", {31'b0, irq}, 32'h0);
    tip = 1'b0;
    @(posedge clk); #1;
    check("int_on_fall", {31'b0, irq}, 32'h1);
    rd(5'h00, 32'h0000003C, "rd_rx0");
    @(posedge clk); #1;
    check("int_cleared", {31'b0, irq}, 32'h0);
    rd(5'h04, 32'h0, "rd_rx1");
    rd(5'h10, 32'h00001000, "rd_ctrl_idle");

    // Byte lanes on CTRL and DIVIDER
    wr(5'h10, 32'h00000F07, 4'b0001, "wr_ctrl_lane0");
    rd(5'h10, 32'h00001007, "rd_ctrl_lane0");
    check("len_out", {29'b0, len}, 32'h7);
    wr(5'h14, 32'h00001234, 4'b0010, "wr_div_lane1");
    rd(5'h14, 32'h000012FF, "rd_div_lane1");

    // Automatic slave select
    wr(5'h18, 32'h00000005, 4'b0001, "wr_ss");
    wr(5'h10, 32'h00003000, 4'b0010, "wr_ctrl_ass");
    check("ass_idle", {24'b0, ss_pad}, 32'hFF);
    tip = 1'b1;
    #1;
    check("ass_busy", {24'b0, ss_pad}, 32'hFA);
    @(posedge clk); #1;
    tip = 1'b0;
    #1;
    check("ass_done", {24'b0, ss_pad}, 32'hFF);
    @(posedge clk); #1;

    // Unmapped address: err only, nothing changes
    bus_start(5'h1C, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0, "unmapped");
    bus_wait("unmapped");
    rd(5'h10, 32'h00003007, "rd_ctrl_after_err");
    rd(5'h14, 32'h000012FF, "rd_div_after_err");
    rd(5'h18, 32'h00000005, "rd_ss_after_err");

    // Manual slave select follows SS regardless of tip
    wr(5'h10, 32'h00000000, 4'b0010, "wr_ctrl_noass");
    check("manual_ss", {24'b0, ss_pad}, 32'hFA);

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
